// File: rtl/quad_decoder.sv
// ============================================================================
// Module   : quad_decoder
// Brief    : Debounced 4x quadrature decoder, sampled on divided-clock ticks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module quad_decoder #(
    parameter int CNT_W    = 16,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sample_clk_i,
    input  logic             enc_a_i,
    input  logic             enc_b_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] pos_o,
    output logic             dir_o,
    output logic             step_o,
    output logic             err_o
);

    localparam logic [3:0] c_run_max = 4'(DEBOUNCE);

    // Bit 2 = divided clock, bits 1:0 = {A, B}
    logic [2:0] r_meta;
    logic [2:0] r_sync;
    logic       r_sclk_prev;

    logic       r_init;
    logic [1:0] r_filt;
    logic [1:0] r_cand;
    logic [3:0] r_run;

    logic       w_tick;
    logic [1:0] w_samp;
    logic       w_init_nxt;
    logic [1:0] w_filt_nxt;
    logic [1:0] w_cand_nxt;
    logic [3:0] w_run_nxt;
    logic [3:0] w_run_inc;
    logic       w_accept;
    logic [1:0] w_phase_old;
    logic [1:0] w_phase_new;
    logic [1:0] w_delta;

    // ------------------------------------------------------------------
    // Synchronisers and tick detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta      <= 3'b000;
            r_sync      <= 3'b000;
            r_sclk_prev <= 1'b0;
        end else begin
            r_meta      <= {sample_clk_i, enc_a_i, enc_b_i};
            r_sync      <= r_meta;
            r_sclk_prev <= r_sync[2];
        end
    end

    assign w_tick = r_sync[2] & ~r_sclk_prev;
    assign w_samp = r_sync[1:0];

    // ------------------------------------------------------------------
    // Debounce filter
    // ------------------------------------------------------------------
    always_comb begin
        w_init_nxt = r_init;
        w_filt_nxt = r_filt;
        w_cand_nxt = r_cand;
        w_run_nxt  = r_run;
        w_run_inc  = r_run;
        w_accept   = 1'b0;
        if (w_tick) begin
            if (r_init) begin
                // First sample after reset only seeds the filter
                w_filt_nxt = w_samp;
                w_init_nxt = 1'b0;
            end else if (w_samp == r_filt) begin
                w_run_nxt = 4'd0;
            end else begin
                if (w_samp == r_cand) begin
                    w_run_inc = (r_run >= c_run_max) ? c_run_max : r_run + 4'd1;
                end else begin
                    w_cand_nxt = w_samp;
                    w_run_inc  = 4'd1;
                end
                if (w_run_inc == c_run_max) begin
                    w_accept   = 1'b1;
                    w_filt_nxt = w_samp;
                    w_run_nxt  = 4'd0;
                end else begin
                    w_run_nxt = w_run_inc;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_init <= 1'b1;
            r_filt <= 2'b00;
            r_cand <= 2'b00;
            r_run  <= 4'd0;
        end else begin
            r_init <= w_init_nxt;
            r_filt <= w_filt_nxt;
            r_cand <= w_cand_nxt;
            r_run  <= w_run_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Quadrature decode
    // ------------------------------------------------------------------
    // Gray {A,B} to phase: 00->0, 10->1, 11->2, 01->3; CW advances the phase.
    assign w_phase_old = {r_filt[0], r_filt[1] ^ r_filt[0]};
    assign w_phase_new = {w_samp[0], w_samp[1] ^ w_samp[0]};
    assign w_delta     = w_phase_new - w_phase_old;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pos_o  <= '0;
            dir_o  <= 1'b0;
            step_o <= 1'b0;
            err_o  <= 1'b0;
        end else if (clr_i) begin
            pos_o  <= '0;
            step_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            step_o <= 1'b0;
            if (w_accept) begin
                case (w_delta)
                    2'd1: begin
                        pos_o  <= pos_o + CNT_W'(1);
                        dir_o  <= 1'b1;
                        step_o <= 1'b1;
                    end
                    2'd3: begin
                        pos_o  <= pos_o - CNT_W'(1);
                        dir_o  <= 1'b0;
                        step_o <= 1'b1;
                    end
                    2'd2: begin
                        err_o <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// ============================================================================
// Module   : tb_quad_decoder
// Brief    : Directed plus randomized bench for quad_decoder with a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_quad_decoder;

    localparam int DEB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_clk;
    logic        enc_a;
    logic        enc_b;
    logic        clr;
    logic [15:0] pos;
    logic        dir;
    logic        step;
    logic        err;
    logic [3:0]  pos_n;
    logic        dir_n;
    logic        step_n;
    logic        err_n;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit       m_init;
    bit [1:0] m_filt;
    bit [1:0] m_last;
    int       m_streak;
    int       m_pos;
    bit       m_dir;
    bit       m_err;

    always #5 clk = ~clk;

    quad_decoder #(.CNT_W(16), .DEBOUNCE(DEB)) dut (
        .clk_i(clk), .rst_i(rst), .sample_clk_i(sample_clk),
        .enc_a_i(enc_a), .enc_b_i(enc_b), .clr_i(clr),
        .pos_o(pos), .dir_o(dir), .step_o(step), .err_o(err)
    );

    // Narrow counter instance: same stimulus, exposes signed wrap at 7 -> 8
    quad_decoder #(.CNT_W(4), .DEBOUNCE(DEB)) dut_n (
        .clk_i(clk), .rst_i(rst), .sample_clk_i(sample_clk),
        .enc_a_i(enc_a), .enc_b_i(enc_b), .clr_i(clr),
        .pos_o(pos_n), .dir_o(dir_n), .step_o(step_n), .err_o(err_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int phase(input bit [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_init   = 1'b1;
        m_filt   = 2'b00;
        m_last   = 2'b00;
        m_streak = 0;
        m_pos    = 0;
        m_dir    = 1'b0;
        m_err    = 1'b0;
    endtask

    // A new value is accepted once the last DEB samples agree and differ from the filtered state.
    task automatic model_tick(input bit [1:0] s, input bit c, output bit st);
        int d;
        st = 1'b0;
        if (m_init) begin
            m_init   = 1'b0;
            m_filt   = s;
            m_last   = s;
            m_streak = 1;
        end else begin
            if (s == m_last) m_streak++;
            else begin
                m_last   = s;
                m_streak = 1;
            end
            if (s != m_filt && m_streak == DEB) begin
                d      = (phase(s) - phase(m_filt) + 4) % 4;
                m_filt = s;
                if (!c) begin
                    if (d == 1) begin
                        m_pos++;
                        m_dir = 1'b1;
                        st    = 1'b1;
                    end else if (d == 3) begin
                        m_pos--;
                        m_dir = 1'b0;
                        st    = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
        if (c) begin
            m_pos = 0;
            m_err = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pos"},   32'(pos),   32'(m_pos & 16'hFFFF));
        check({tag, "_pos_n"}, 32'(pos_n), 32'(m_pos & 4'hF));
        check({tag, "_dir"},   32'(dir),   32'(m_dir));
        check({tag, "_err"},   32'(err),   32'(m_err));
    endtask

    // One divided-clock period carrying sample ab; optionally clr in the decode cycle.
    task automatic tick(input bit [1:0] ab, input bit with_clr);
        bit st;
        enc_a = ab[1];
        enc_b = ab[0];
        repeat (2) @(negedge clk);
        sample_clk = 1'b1;
        model_tick(ab, with_clr, st);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                clr = 1'b0;
                check("step", 32'(step), 32'(st));
                check("step_n", 32'(step_n), 32'(st));
                check_state("tick");
            end else begin
                check("step_idle", 32'(step), 32'h0);
            end
            if (c == 2 && with_clr) clr = 1'b1;
        end
        sample_clk = 1'b0;
    endtask

    task automatic hold(input bit [1:0] ab, input int n);
        for (int i = 0; i < n; i++) tick(ab, 1'b0);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        m_pos = 0;
        m_err = 1'b0;
        check_state("clr");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit [1:0] ab;
        int       n;
        rst        = 1'b1;
        sample_clk = 1'b0;
        enc_a      = 1'b1;
        enc_b      = 1'b1;
        clr        = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_pos", 32'(pos), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        check("rst_dir", 32'(dir), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        // Power-up sample of 11 must not flag an error
        tick(2'b11, 1'b0);
        check("init_err", 32'(err), 32'h0);
        hold(2'b01, 4);
        hold(2'b00, 4);
        clear_pulse();

        // CW then CCW, then one more CCW step below zero
        hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4); hold(2'b00, 4);
        check("cw_pos", 32'(pos), 32'd4);
        check("cw_dir", 32'(dir), 32'd1);
        hold(2'b01, 4); hold(2'b11, 4); hold(2'b10, 4); hold(2'b00, 4);
        check("ccw_pos", 32'(pos), 32'd0);
        hold(2'b01, 4);
        check("under_pos", 32'(pos), 32'hFFFF);
        hold(2'b00, 4);

        // Glitch shorter than the debounce window
        tick(2'b10, 1'b0); tick(2'b10, 1'b0); hold(2'b00, 3);

        // Illegal double-bit jump, then clear
        hold(2'b11, 3);
        check("illegal_err", 32'(err), 32'd1);
        clear_pulse();

        // Eight CW steps: narrow counter wraps 7 -> 8
        for (int i = 0; i < 2; i++) begin
            hold(2'b01, 3); hold(2'b00, 3); hold(2'b10, 3); hold(2'b11, 3);
        end
        check("wrap_pos_n", 32'(pos_n), 32'h8);

        // Clear coincident with an accepted step
        tick(2'b01, 1'b0); tick(2'b01, 1'b0); tick(2'b01, 1'b1);

        // Reset in the middle of a debounce run
        tick(2'b00, 1'b0); tick(2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_pos", 32'(pos), 32'h0);
        check("midrst_dir", 32'(dir), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick(2'b00, 1'b0);
        hold(2'b10, 3);

        // Randomized walk including illegal jumps and sporadic clears
        for (int k = 0; k < 250; k++) begin
            ab = 2'($urandom_range(0, 3));
            n  = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) tick(ab, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
Quadrature encoder front end for the encoder test game.
- Consumes the slow divided clock from the clock divider stage as a sample strobe.
- Synchronises and debounces the raw encoder A/B inputs at that rate, then decodes 4x quadrature into a signed position, a direction flag, a step pulse and a sticky error flag.
- Runs entirely in the fast system clock domain; the divided clock is treated as data, never as a clock.

Parameters:
CNT_W, 16, width of the position counter (two's complement).
DEBOUNCE, 3, consecutive identical samples required to accept a new A/B state (legal range 1..15).

Ports:
clk_i  in  1  system clock; all flops on rising edge.
rst_i  in  1  asynchronous, active-high reset.
sample_clk_i  in  1  divided clock from the divider stage; its rising edge defines a sample tick.
enc_a_i  in  1  raw encoder channel A, asynchronous.
enc_b_i  in  1  raw encoder channel B, asynchronous.
clr_i  in  1  synchronous clear of position and error.
pos_o  out  CNT_W  signed position count.
dir_o  out  1  direction of last valid step: 1 = CW (A leads B), 0 = CCW.
step_o  out  1  one-cycle pulse per accepted count.
err_o  out  1  sticky illegal-transition flag.

Behaviour:
Reset:
- Asserting rst_i immediately clears all state: pos_o=0, dir_o=0, step_o=0, err_o=0, sync flops=0, init flag=1, run=0, filt=00, cand=00.
- Reset mid-operation discards any pending debounce run.

Synchronisers and tick:
- enc_a_i, enc_b_i and sample_clk_i each pass through a 2-flop synchroniser.
- tick = synced sample_clk AND NOT its registered previous value. It is one clk_i cycle wide, once per divided-clock period.

Sampled state: samp = {a_sync, b_sync}.

Debounce, evaluated only on tick:
- If init=1: filt<=samp, init<=0. No step, no error. This avoids a false error at power-up.
- Else if samp==filt: run<=0.
- Else if samp==cand: run<=run+1, saturating at DEBOUNCE.
- Else: cand<=samp, run<=1.
- Accept when the new run value equals DEBOUNCE. On accept: filt<=samp, run<=0, and raise an internal accept strobe for one cycle carrying old and new filt.
- With DEBOUNCE=1, a new value is accepted on its first tick.

Decode (state = {A,B}), registered in the cycle after accept:
- CW sequence 00->10->11->01->00: pos+=1, dir_o<=1, step_o=1.
- CCW sequence 00->01->11->10->00: pos-=1, dir_o<=0, step_o=1.
- Both bits changed (00<->11, 10<->01): err_o<=1. pos and dir_o unchanged, step_o=0.

Arithmetic:
- pos wraps modulo 2^CNT_W: +1 from 0x7FFF gives 0x8000 for CNT_W=16; -1 from 0 gives 0xFFFF.

clr_i:
- Has priority over a coincident step or error: pos_o<=0, err_o<=0, step_o=0, dir_o held.
- Does not touch filt or the debounce state.

Latency: from a stable input edge to step_o is 2 clk (sync) + DEBOUNCE ticks + 1 clk.

Timing of sample_clk_i: input pulses shorter than 2 clk_i cycles may be missed. The divider guarantees pulses of at least DIVIDED_BY cycles.

Test Plan:
- Reset with A=1,B=1, release, drive one tick -> filt=11, pos_o=0, err_o=0, no step_o.
- DEBOUNCE=3, CW sequence 00->10->11->01->00, each value held for 4 ticks -> four step_o pulses, pos_o=4, dir_o=1. Each step_o appears 1 clk after the 3rd matching tick.
- Reverse sequence from pos=4 -> pos_o=0, dir_o=0. Then one more CCW step -> pos_o=0xFFFF.
- Glitch: from 00, A high for 2 ticks then back to 0 -> no step_o, pos_o unchanged, run returns to 0.
- Illegal: from stable 00, jump to 11 held 3 ticks -> err_o=1, pos_o unchanged. Then assert clr_i for 1 cycle -> err_o=0, pos_o=0.
- Simultaneous events and reset:
  - Pre-load pos=0x7FFF, do a CW step -> 0x8000.
  - Assert clr_i in the same cycle as a step -> pos_o=0, step_o=0.
  - Assert rst_i mid-debounce (run=2) -> all outputs 0 and init=1.
